// File: rtl/game_flow_ctrl.sv
// Game sequencer for the plane-war design: IDLE/PLAY/PAUSE/OVER state machine,
// lives/score bookkeeping, invulnerability and game-over hold timers.
// Per-pixel crash strobes are folded into at most one life/score event per
// frame, evaluated on the falling edge of v_sync.
module game_flow_ctrl #(
  parameter int LIVES_INIT       = 3,
  parameter int LIVES_W          = 3,
  parameter int SCORE_W          = 14,
  parameter int SCORE_PER_HIT    = 1,
  parameter int INVULN_FRAMES    = 60,
  parameter int OVER_HOLD_FRAMES = 120
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               v_sync_i,
  input  logic               start_i,
  input  logic               pause_i,
  input  logic               crash_me_enemy_i,
  input  logic               crash_enemy_bullet_i,
  output logic [1:0]         game_status_o,
  output logic               gamestart_o,
  output logic               gameover_o,
  output logic               run_en_o,
  output logic               invuln_o,
  output logic [LIVES_W-1:0] lives_o,
  output logic [SCORE_W-1:0] score_o
);

  // state    | meaning
  // ST_IDLE  | waiting for the first start press
  // ST_PLAY  | game running, objects move, crashes counted per frame
  // ST_PAUSE | everything frozen until the next pause press
  // ST_OVER  | final lives/score shown; start accepted once hold reaches 0
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W:0]   SCORE_INC = (SCORE_W+1)'(SCORE_PER_HIT);

  state_t               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [7:0]           invuln_q, invuln_d;
  logic [7:0]           hold_q, hold_d;
  logic                 hit_q, hit_d;
  logic                 kill_q, kill_d;
  logic                 vs_prev_q, vs_prev_d;
  logic                 start_prev_q, start_prev_d;
  logic                 pause_prev_q, pause_prev_d;
  logic                 gamestart_q, gamestart_d;
  logic                 gameover_q, gameover_d;

  logic                 tick;
  logic                 start_edge;
  logic                 pause_edge;
  logic                 life_lost;
  logic                 game_end;
  logic                 restart;
  logic [SCORE_W:0]     score_sum;

  // Edge detection and derived per-cycle events
  always_comb begin
    tick       = vs_prev_q & ~v_sync_i;
    start_edge = start_i & ~start_prev_q;
    pause_edge = pause_i & ~pause_prev_q;
    life_lost  = (state_q == ST_PLAY) && tick && hit_q && (invuln_q == 8'd0);
    // Lives never reach 0 while playing, so losing one at 1 ends the game.
    game_end   = life_lost && (lives_q == LIVES_W'(1));
    restart    = start_edge && ((state_q == ST_IDLE) ||
                                ((state_q == ST_OVER) && (hold_q == 8'd0)));
    score_sum  = {1'b0, score_q} + SCORE_INC;
  end

  // State register and all datapath flops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      lives_q      <= LIVES_W'(LIVES_INIT);
      score_q      <= '0;
      invuln_q     <= 8'd0;
      hold_q       <= 8'd0;
      hit_q        <= 1'b0;
      kill_q       <= 1'b0;
      vs_prev_q    <= 1'b0;
      start_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
      gamestart_q  <= 1'b0;
      gameover_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      invuln_q     <= invuln_d;
      hold_q       <= hold_d;
      hit_q        <= hit_d;
      kill_q       <= kill_d;
      vs_prev_q    <= vs_prev_d;
      start_prev_q <= start_prev_d;
      pause_prev_q <= pause_prev_d;
      gamestart_q  <= gamestart_d;
      gameover_q   <= gameover_d;
    end
  end

  // Next-state decode; a game-ending tick outranks a simultaneous pause press
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_edge) state_d = ST_PLAY;
      ST_PLAY: begin
        if (game_end)        state_d = ST_OVER;
        else if (pause_edge) state_d = ST_PAUSE;
      end
      ST_PAUSE: if (pause_edge) state_d = ST_PLAY;
      ST_OVER:  if (restart) state_d = ST_PLAY;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Counters, crash latches and pulse generation
  always_comb begin
    lives_d      = lives_q;
    score_d      = score_q;
    invuln_d     = invuln_q;
    hold_d       = hold_q;
    hit_d        = 1'b0;
    kill_d       = 1'b0;
    vs_prev_d    = v_sync_i;
    start_prev_d = start_i;
    pause_prev_d = pause_i;
    gamestart_d  = restart;
    gameover_d   = game_end;

    // A strobe landing on the tick cycle belongs to the next frame.
    if (state_q == ST_PLAY) begin
      hit_d  = (tick ? 1'b0 : hit_q)  | crash_me_enemy_i;
      kill_d = (tick ? 1'b0 : kill_q) | crash_enemy_bullet_i;
    end

    if (restart) begin
      lives_d  = LIVES_W'(LIVES_INIT);
      score_d  = '0;
      invuln_d = 8'd0;
    end

    if ((state_q == ST_PLAY) && tick) begin
      if (kill_q) begin
        score_d = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
      end
      if (life_lost) begin
        lives_d = lives_q - LIVES_W'(1);
        if (game_end) hold_d = 8'(OVER_HOLD_FRAMES);
        else          invuln_d = 8'(INVULN_FRAMES);
      end else if (invuln_q != 8'd0) begin
        invuln_d = invuln_q - 8'd1;
      end
    end

    if ((state_q == ST_OVER) && tick && (hold_q != 8'd0)) begin
      hold_d = hold_q - 8'd1;
    end
  end

  // Outputs decoded purely from registers
  always_comb begin
    game_status_o = state_q;
    run_en_o      = (state_q == ST_PLAY);
    invuln_o      = (state_q == ST_PLAY) && (invuln_q != 8'd0);
    gamestart_o   = gamestart_q;
    gameover_o    = gameover_q;
    lives_o       = lives_q;
    score_o       = score_q;
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl: directed stimulus pushes expected
// snapshots; a separate monitor pops and compares them against the outputs.
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        v_sync_i;
  logic        start_i;
  logic        pause_i;
  logic        crash_me_enemy_i;
  logic        crash_enemy_bullet_i;
  logic [1:0]  game_status_o;
  logic        gamestart_o;
  logic        gameover_o;
  logic        run_en_o;
  logic        invuln_o;
  logic [2:0]  lives_o;
  logic [13:0] score_o;

  always #5 clk = ~clk;

  game_flow_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .v_sync_i             (v_sync_i),
    .start_i              (start_i),
    .pause_i              (pause_i),
    .crash_me_enemy_i     (crash_me_enemy_i),
    .crash_enemy_bullet_i (crash_enemy_bullet_i),
    .game_status_o        (game_status_o),
    .gamestart_o          (gamestart_o),
    .gameover_o           (gameover_o),
    .run_en_o             (run_en_o),
    .invuln_o             (invuln_o),
    .lives_o              (lives_o),
    .score_o              (score_o)
  );

  typedef struct {
    logic [1:0]  st;
    logic [2:0]  lives;
    logic [13:0] score;
    logic        run;
    logic        inv;
    int          gs;
    int          go;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  int    gs_cnt = 0;
  int    go_cnt = 0;
  int    exp_gs = 0;
  int    exp_go = 0;

  // Count every high cycle of the pulse outputs so a stretched pulse shows up.
  initial forever begin
    @(negedge clk);
    if (gamestart_o === 1'b1) gs_cnt++;
    if (gameover_o === 1'b1)  go_cnt++;
  end

  // Monitor: compare queued expectations against the sampled outputs.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(negedge clk or negedge rst);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (game_status_o !== e.st || lives_o !== e.lives || score_o !== e.score ||
            run_en_o !== e.run || invuln_o !== e.inv || gs_cnt != e.gs || go_cnt != e.go) begin
          errors++;
          $display("FAIL %s: got st=%0d lives=%0d score=%0d run=%0b inv=%0b gs=%0d go=%0d want st=%0d lives=%0d score=%0d run=%0b inv=%0b gs=%0d go=%0d",
                   n, game_status_o, lives_o, score_o, run_en_o, invuln_o, gs_cnt, go_cnt,
                   e.st, e.lives, e.score, e.run, e.inv, e.gs, e.go);
        end
      end
    end
  end

  task automatic push_exp(input string nm, input logic [1:0] st, input logic [2:0] lv,
                          input logic [13:0] sc, input logic run, input logic inv);
    exp_t e;
    e.st = st; e.lives = lv; e.score = sc; e.run = run; e.inv = inv;
    e.gs = exp_gs; e.go = exp_go;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic confirm_consumed(input string nm);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard entry not consumed, pending=%0d want 0", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic chk_state(input string nm, input logic [1:0] st, input logic [2:0] lv,
                           input logic [13:0] sc, input logic run, input logic inv);
    push_exp(nm, st, lv, sc, run, inv);
    @(negedge clk);
    #2;
    confirm_consumed(nm);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic strobe(input logic me, input logic bl, input int n);
    crash_me_enemy_i = me;
    crash_enemy_bullet_i = bl;
    cyc(n);
    crash_me_enemy_i = 1'b0;
    crash_enemy_bullet_i = 1'b0;
  endtask

  // One frame boundary; strobes/pause optionally coincide with the tick cycle.
  task automatic tick(input logic me, input logic bl, input logic pz);
    v_sync_i = 1'b0;
    crash_me_enemy_i = me;
    crash_enemy_bullet_i = bl;
    pause_i = pz;
    cyc(1);
    v_sync_i = 1'b1;
    crash_me_enemy_i = 1'b0;
    crash_enemy_bullet_i = 1'b0;
    pause_i = 1'b0;
    cyc(1);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_start();
    start_i = 1'b1;
    cyc(1);
    start_i = 1'b0;
  endtask

  task automatic press_pause();
    pause_i = 1'b1;
    cyc(1);
    pause_i = 1'b0;
  endtask

  task automatic sat_ticks(input int n);
    repeat (n) begin
      v_sync_i = 1'b0;
      cyc(1);
      v_sync_i = 1'b1;
      cyc(1);
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b0;
    v_sync_i = 1'b1;
    start_i = 1'b1;
    pause_i = 1'b1;
    crash_me_enemy_i = 1'b0;
    crash_enemy_bullet_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc(2);
    chk_state("reset_idle_buttons_held", 2'd0, 3'd3, 14'd0, 1'b0, 1'b0);

    start_i = 1'b0;
    pause_i = 1'b0;
    cyc(1);
    press_pause();
    chk_state("idle_pause_ignored", 2'd0, 3'd3, 14'd0, 1'b0, 1'b0);

    press_start();
    exp_gs = 1;
    chk_state("start_play", 2'd1, 3'd3, 14'd0, 1'b1, 1'b0);

    strobe(1'b1, 1'b0, 40);
    tick(1'b0, 1'b0, 1'b0);
    chk_state("hit_once_per_frame", 2'd1, 3'd2, 14'd0, 1'b1, 1'b1);

    ticks(9);
    strobe(1'b1, 1'b0, 5);
    tick(1'b0, 1'b0, 1'b0);
    chk_state("hit_during_invuln", 2'd1, 3'd2, 14'd0, 1'b1, 1'b1);

    ticks(49);
    chk_state("invuln_last_frame", 2'd1, 3'd2, 14'd0, 1'b1, 1'b1);

    strobe(1'b1, 1'b0, 5);
    tick(1'b0, 1'b0, 1'b0);
    chk_state("hit_at_invuln_one", 2'd1, 3'd2, 14'd0, 1'b1, 1'b0);

    repeat (5) begin
      strobe(1'b0, 1'b1, 3);
      tick(1'b0, 1'b0, 1'b0);
    end
    chk_state("score_five_frames", 2'd1, 3'd2, 14'd5, 1'b1, 1'b0);

    tick(1'b0, 1'b1, 1'b0);
    chk_state("coincident_kill_deferred", 2'd1, 3'd2, 14'd5, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk_state("coincident_kill_next_frame", 2'd1, 3'd2, 14'd6, 1'b1, 1'b0);

    press_pause();
    chk_state("pause_enter", 2'd2, 3'd2, 14'd6, 1'b0, 1'b0);
    strobe(1'b1, 1'b1, 4);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk_state("pause_frozen", 2'd2, 3'd2, 14'd6, 1'b0, 1'b0);
    press_pause();
    chk_state("pause_resume", 2'd1, 3'd2, 14'd6, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk_state("resume_latches_clear", 2'd1, 3'd2, 14'd6, 1'b1, 1'b0);

    // Bullet held high: first tick only arms the latch, every later tick adds 1.
    crash_enemy_bullet_i = 1'b1;
    sat_ticks(16376);
    chk_state("score_near_max", 2'd1, 3'd2, 14'd16381, 1'b1, 1'b0);
    sat_ticks(2);
    chk_state("score_reaches_max", 2'd1, 3'd2, 14'd16383, 1'b1, 1'b0);
    sat_ticks(3);
    chk_state("score_saturated", 2'd1, 3'd2, 14'd16383, 1'b1, 1'b0);
    crash_enemy_bullet_i = 1'b0;
    cyc(1);

    strobe(1'b1, 1'b0, 3);
    tick(1'b0, 1'b0, 1'b0);
    chk_state("second_life_lost", 2'd1, 3'd1, 14'd16383, 1'b1, 1'b1);
    ticks(60);
    chk_state("invuln_expired", 2'd1, 3'd1, 14'd16383, 1'b1, 1'b0);

    strobe(1'b1, 1'b0, 3);
    tick(1'b0, 1'b0, 1'b1);
    exp_go = 1;
    chk_state("over_beats_pause", 2'd3, 3'd0, 14'd16383, 1'b0, 1'b0);

    ticks(50);
    press_start();
    chk_state("start_ignored_hold70", 2'd3, 3'd0, 14'd16383, 1'b0, 1'b0);
    ticks(69);
    press_start();
    chk_state("start_ignored_hold1", 2'd3, 3'd0, 14'd16383, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    press_start();
    exp_gs = 2;
    chk_state("restart_after_hold", 2'd1, 3'd3, 14'd0, 1'b1, 1'b0);

    strobe(1'b1, 1'b0, 3);
    tick(1'b0, 1'b0, 1'b0);
    chk_state("pre_reset_play", 2'd1, 3'd2, 14'd0, 1'b1, 1'b1);

    // Reset asserted between edges; outputs must clear before the next edge.
    @(posedge clk);
    #2;
    push_exp("async_reset_immediate", 2'd0, 3'd3, 14'd0, 1'b0, 1'b0);
    rst = 1'b0;
    start_i = 1'b1;
    #2;
    confirm_consumed("async_reset_immediate");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    cyc(3);
    chk_state("reset_release_start_held", 2'd0, 3'd3, 14'd0, 1'b0, 1'b0);
    start_i = 1'b0;
    cyc(1);
    press_start();
    exp_gs = 3;
    chk_state("start_after_reset", 2'd1, 3'd3, 14'd0, 1'b1, 1'b0);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
